// File: rtl/mont_mult.sv
// rtl/mont_mult.sv - bit-serial radix-2 Montgomery modular multiplier, S = A*B*2^-WIDTH mod N
module mont_mult #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [SW-1:0]    s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] so_q, so_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [SW-1:0]    t_add_b;
  logic [SW-1:0]    t_add_n;

  // One Montgomery step: add B when the current A bit is set, make the sum even with N, halve
  always_comb begin
    t_add_b = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    t_add_n = t_add_b + (t_add_b[0] ? {2'b00, n_q} : '0);
  end

  // Next-state logic; A is shifted right each iteration so its LSB is always the active bit.
  // DONE hands straight over to a new request when start is held, sustaining one result per WIDTH+2 cycles.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          a_d     = a_i;
          b_d     = b_i;
          n_d     = n_i;
          s_d     = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        s_d   = t_add_n >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = CORR;
        end
      end
      CORR: begin
        if (s_q >= {2'b00, n_q}) begin
          so_d = WIDTH'(s_q - {2'b00, n_q});
        end else begin
          so_d = WIDTH'(s_q);
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          a_d     = a_i;
          b_d     = b_i;
          n_d     = n_i;
          s_d     = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = CALC;
        end else begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      so_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign s_o   = so_q;

endmodule
